// File: rtl/mux_scan_reg.sv
// Registered W-bit, N-channel multiplexer with manual select and round-robin auto-scan.
// Outputs carry a valid flag, the channel tag and a one-cycle wrap pulse.
module mux_scan_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]          Sel,
  input  logic                      Mode,
  input  logic                      En,
  output logic [WIDTH-1:0]          Out,
  output logic                      Out_valid,
  output logic [SEL_W-1:0]          Ch,
  output logic                      Wrap
);

  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LastCh    = SEL_W'(CHANNELS - 1);
  localparam logic [DW-1:0]    DwellLast = DW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

  state_e            state_q;
  logic [SEL_W-1:0]  ch_cnt_q;
  logic [DW-1:0]     dwell_cnt_q;

  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH-1:0]  scan_data;
  logic              sel_legal;

  // Index decode over the legal channels only; a select outside 0..CHANNELS-1 never matches.
  always_comb begin
    sel_data  = '0;
    scan_data = '0;
    sel_legal = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (Sel == SEL_W'(k)) begin
        sel_data  = I[k*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
      if (ch_cnt_q == SEL_W'(k)) begin
        scan_data = I[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ch_cnt_q    <= '0;
      dwell_cnt_q <= '0;
      Out         <= '0;
      Out_valid   <= 1'b0;
      Ch          <= '0;
      Wrap        <= 1'b0;
    end else if (!En) begin
      // Counters and Out/Ch freeze.
      state_q   <= StIdle;
      Out_valid <= 1'b0;
      Wrap      <= 1'b0;
    end else if (!Mode) begin
      state_q     <= StManual;
      ch_cnt_q    <= '0;
      dwell_cnt_q <= '0;
      Out         <= sel_legal ? sel_data : '0;
      Ch          <= Sel;
      Out_valid   <= sel_legal;
      Wrap        <= 1'b0;
    end else if (state_q != StScan) begin
      // Entry edge: restart at channel 0; first sample appears on the following edge.
      state_q     <= StScan;
      ch_cnt_q    <= '0;
      dwell_cnt_q <= '0;
      Out_valid   <= 1'b0;
      Wrap        <= 1'b0;
    end else begin
      Out       <= scan_data;
      Ch        <= ch_cnt_q;
      Out_valid <= 1'b1;
      // Previous sample was the last channel and the counter has come back to 0.
      Wrap      <= (ch_cnt_q == '0) && Out_valid && (Ch == LastCh);
      if (dwell_cnt_q == DwellLast) begin
        dwell_cnt_q <= '0;
        ch_cnt_q    <= (ch_cnt_q == LastCh) ? '0 : ch_cnt_q + 1'b1;
      end else begin
        dwell_cnt_q <= dwell_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Self-checking bench for mux_scan_reg: directed stimulus, a cycle-count scan model
// compared every cycle, plus literal expectations at key points.
module tb_mux_scan_reg;

  localparam int WIDTH = 8;
  localparam int CH    = 16;
  localparam int CH2   = 12;
  localparam int DWELL = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CH*WIDTH-1:0] I;
  logic [3:0]          Sel;
  logic                Mode, En;
  logic [WIDTH-1:0]    Out, Out2;
  logic                Out_valid, Out_valid2, Wrap, Wrap2;
  logic [3:0]          Ch, Ch2;

  int checks = 0;
  int failures = 0;

  mux_scan_reg #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(4), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .Sel(Sel), .Mode(Mode), .En(En),
    .Out(Out), .Out_valid(Out_valid), .Ch(Ch), .Wrap(Wrap)
  );

  mux_scan_reg #(.WIDTH(WIDTH), .CHANNELS(CH2), .SEL_W(4), .DWELL(DWELL)) dut12 (
    .clk(clk), .rst_n(rst_n), .I(I[CH2*WIDTH-1:0]), .Sel(Sel), .Mode(Mode), .En(En),
    .Out(Out2), .Out_valid(Out_valid2), .Ch(Ch2), .Wrap(Wrap2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs derived from the mode requested at each edge and, in scan,
  // from the number of scan samples produced since entry.
  logic [7:0] m_out;
  logic       m_valid, m_wrap;
  logic [3:0] m_ch;
  int         m_mode;   // 0 idle, 1 manual, 2 scan
  int         scan_t;

  function automatic logic [7:0] chan(input int k);
    return I[k*WIDTH +: WIDTH];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = 8'h00; m_valid = 1'b0; m_ch = 4'd0; m_wrap = 1'b0; m_mode = 0; scan_t = 0;
    end else if (!En) begin
      m_mode = 0; m_valid = 1'b0; m_wrap = 1'b0;
    end else if (!Mode) begin
      m_mode = 1; m_ch = Sel; m_wrap = 1'b0;
      m_valid = (int'(Sel) < CH);
      m_out = m_valid ? chan(int'(Sel)) : 8'h00;
    end else if (m_mode != 2) begin
      m_mode = 2; scan_t = 0; m_valid = 1'b0; m_wrap = 1'b0;
    end else begin
      m_ch    = 4'((scan_t / DWELL) % CH);
      m_out   = chan(int'(m_ch));
      m_valid = 1'b1;
      m_wrap  = (scan_t > 0) && (scan_t % (DWELL * CH) == 0);
      scan_t++;
    end
  end

  always @(negedge clk) begin
    chk("model_out", {24'd0, Out}, {24'd0, m_out});
    chk("model_valid", {31'd0, Out_valid}, {31'd0, m_valid});
    chk("model_ch", {28'd0, Ch}, {28'd0, m_ch});
    chk("model_wrap", {31'd0, Wrap}, {31'd0, m_wrap});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string name, input logic [7:0] o, input logic v,
                         input logic [3:0] c, input logic w);
    chk({name, "_out"}, {24'd0, Out}, {24'd0, o});
    chk({name, "_valid"}, {31'd0, Out_valid}, {31'd0, v});
    chk({name, "_ch"}, {28'd0, Ch}, {28'd0, c});
    chk({name, "_wrap"}, {31'd0, Wrap}, {31'd0, w});
  endtask

  initial begin
    rst_n = 1'b0; En = 1'b0; Mode = 1'b0; Sel = 4'd0;
    for (int k = 0; k < CH; k++) I[k*WIDTH +: WIDTH] = 8'h10 + 8'(k);

    // Reset held over three edges, released mid-cycle.
    #1;
    chk_out("rst_imm", 8'h00, 1'b0, 4'd0, 1'b0);
    step(3);
    chk_out("rst_hold", 8'h00, 1'b0, 4'd0, 1'b0);
    #1 rst_n = 1'b1;
    step(1);
    chk_out("rst_rel", 8'h00, 1'b0, 4'd0, 1'b0);

    // Manual select.
    En = 1'b1; Mode = 1'b0; Sel = 4'd5;
    step(1);
    chk_out("man5", 8'h15, 1'b1, 4'd5, 1'b0);
    chk("man5_dut12_out", {24'd0, Out2}, 32'h15);
    Sel = 4'd15;
    step(1);
    chk_out("man15", 8'h1F, 1'b1, 4'd15, 1'b0);

    // Illegal select on the 12-channel build.
    Sel = 4'd13;
    step(1);
    chk("ill_out", {24'd0, Out2}, 32'h00);
    chk("ill_valid", {31'd0, Out_valid2}, 32'd0);
    chk("ill_ch", {28'd0, Ch2}, 32'd13);
    chk_out("sel13_full", 8'h1D, 1'b1, 4'd13, 1'b0);

    // Scan: entry edge, then samples c = 1..70.
    Mode = 1'b1;
    step(1);
    chk("entry_valid", {31'd0, Out_valid}, 32'd0);
    for (int c = 1; c <= 70; c++) begin
      step(1);
      if (c == 1)  chk_out("scan_c1", 8'h10, 1'b1, 4'd0, 1'b0);
      if (c == 8)  chk_out("scan_c8", 8'h11, 1'b1, 4'd1, 1'b0);
      if (c == 64) chk_out("scan_c64", 8'h1F, 1'b1, 4'd15, 1'b0);
      if (c == 65) chk_out("scan_c65", 8'h10, 1'b1, 4'd0, 1'b1);
      if (c == 66) chk_out("scan_c66", 8'h10, 1'b1, 4'd0, 1'b0);
    end

    // Freeze at channel 7 and restart.
    Mode = 1'b0; step(1);
    Mode = 1'b1; step(1);
    step(29);
    chk_out("at_ch7", 8'h17, 1'b1, 4'd7, 1'b0);
    En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk_out("frozen", 8'h17, 1'b0, 4'd7, 1'b0);
    end
    En = 1'b1;
    step(2);
    chk_out("restart", 8'h10, 1'b1, 4'd0, 1'b0);

    // Live input change during dwell on channel 0.
    I[7:0] = 8'hA5;
    step(1);
    chk_out("live", 8'hA5, 1'b1, 4'd0, 1'b0);
    I[7:0] = 8'h10;

    // Mode switch at channel 3, second dwell cycle.
    step(12);
    chk_out("at_ch3", 8'h13, 1'b1, 4'd3, 1'b0);
    Mode = 1'b0; Sel = 4'd9;
    step(1);
    chk_out("switch9", 8'h19, 1'b1, 4'd9, 1'b0);
    Mode = 1'b1;
    step(2);
    chk_out("rescan", 8'h10, 1'b1, 4'd0, 1'b0);

    // Reset mid-scan at channel 10.
    step(40);
    chk_out("at_ch10", 8'h1A, 1'b1, 4'd10, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 8'h00, 1'b0, 4'd0, 1'b0);
    step(2);
    chk_out("rst_mid_hold", 8'h00, 1'b0, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
